// File: rtl/invtlb_walker_pkg.sv
// Shared INVTLB definitions: op encodings, walker states, field widths and latched operand record.
package invtlb_walker_pkg;

  localparam int unsigned ASID_W = 10;
  localparam int unsigned VPPN_W = 19;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] INV_ALL0     = OP_W'(0);
  localparam logic [OP_W-1:0] INV_ALL1     = OP_W'(1);
  localparam logic [OP_W-1:0] INV_G        = OP_W'(2);
  localparam logic [OP_W-1:0] INV_NG       = OP_W'(3);
  localparam logic [OP_W-1:0] INV_ASID     = OP_W'(4);
  localparam logic [OP_W-1:0] INV_ASID_VA  = OP_W'(5);
  localparam logic [OP_W-1:0] INV_GASID_VA = OP_W'(6);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ASID_W-1:0] asid;
    logic [VPPN_W-1:0] vppn;
  } inv_req_t;

endpackage

// File: rtl/invtlb_walker_match.sv
// Combinational INVTLB match of one TLB entry against an op/asid/vppn criterion.
module invtlb_walker_match
  import invtlb_walker_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [ASID_W-1:0] asid,
  input  logic [VPPN_W-1:0] vppn,
  input  logic              r_g,
  input  logic [ASID_W-1:0] r_asid,
  input  logic [VPPN_W-1:0] r_vppn,
  input  logic              r_ps4mb,
  output logic              match
);

  logic va_hit;
  logic asid_hit;

  always_comb begin
    // 4MB pages only compare the upper ten vppn bits
    va_hit   = r_ps4mb ? (r_vppn[VPPN_W-1:9] == vppn[VPPN_W-1:9]) : (r_vppn == vppn);
    asid_hit = (r_asid == asid);
    match    = 1'b0;
    case (op)
      INV_ALL0, INV_ALL1: match = 1'b1;
      INV_G:              match = r_g;
      INV_NG:             match = ~r_g;
      INV_ASID:           match = ~r_g & asid_hit;
      INV_ASID_VA:        match = ~r_g & asid_hit & va_hit;
      INV_GASID_VA:       match = (r_g | asid_hit) & va_hit;
      default:            match = 1'b0;
    endcase
  end

endmodule

// File: rtl/invtlb_walker.sv
// INVTLB sequencer: walks every TLB entry once per op and clears E on matching entries.
module invtlb_walker
  import invtlb_walker_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [4:0]        start_op,
  input  logic [9:0]        start_asid,
  input  logic [31:0]       start_va,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              op_err,
  output logic [IDX_W-1:0]  r_index,
  input  logic              r_e,
  input  logic              r_g,
  input  logic [9:0]        r_asid,
  input  logic [18:0]       r_vppn,
  input  logic              r_ps4mb,
  output logic              inv_we,
  output logic [IDX_W-1:0]  inv_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] cnt, cnt_d;
  inv_req_t         req, req_d;
  logic             err, err_d;
  logic             hit;
  logic             unused_va_low;

  assign unused_va_low = ^start_va[12:0];

  invtlb_walker_match u_match (
    .op      (req.op),
    .asid    (req.asid),
    .vppn    (req.vppn),
    .r_g     (r_g),
    .r_asid  (r_asid),
    .r_vppn  (r_vppn),
    .r_ps4mb (r_ps4mb),
    .match   (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      req   <= req_d;
      err   <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    req_d       = req;
    err_d       = err;
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    op_err      = 1'b0;
    inv_we      = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        cnt_d       = '0;
        if (start_valid) begin
          req_d.op   = start_op;
          req_d.asid = start_asid;
          req_d.vppn = start_va[31:13];
          err_d      = (start_op > INV_GASID_VA);
          state_d    = err_d ? ST_DONE : ST_WALK;
        end
      end
      ST_WALK: begin
        busy   = 1'b1;
        inv_we = r_e & hit;
        if (cnt == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt + IDX_W'(1);
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = ~flush;
        op_err  = err & ~flush;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // a flush cancels the op but lets this cycle's invalidate land
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign r_index   = cnt;
  assign inv_index = cnt;

endmodule

// File: tb/tb_invtlb_walker.sv
// Self-checking bench for invtlb_walker: directed vector table plus randomized ops against a TLB model.
module tb_invtlb_walker;

  localparam int TLBNUM = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [4:0]  start_op;
  logic [9:0]  start_asid;
  logic [31:0] start_va;
  logic        flush;
  logic        busy, done, op_err;
  logic [3:0]  r_index;
  logic        r_e, r_g, r_ps4mb;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  logic        inv_we;
  logic [3:0]  inv_index;

  logic        tlb_e    [TLBNUM];
  logic        tlb_g    [TLBNUM];
  logic [9:0]  tlb_asid [TLBNUM];
  logic [18:0] tlb_vppn [TLBNUM];
  logic        tlb_ps   [TLBNUM];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          setup;
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [31:0] va;
    int          flush_at;
    logic [15:0] mask;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  assign r_e     = tlb_e[r_index];
  assign r_g     = tlb_g[r_index];
  assign r_asid  = tlb_asid[r_index];
  assign r_vppn  = tlb_vppn[r_index];
  assign r_ps4mb = tlb_ps[r_index];

  invtlb_walker #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_op    (start_op),
    .start_asid  (start_asid),
    .start_va    (start_va),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .op_err      (op_err),
    .r_index     (r_index),
    .r_e         (r_e),
    .r_g         (r_g),
    .r_asid      (r_asid),
    .r_vppn      (r_vppn),
    .r_ps4mb     (r_ps4mb),
    .inv_we      (inv_we),
    .inv_index   (inv_index)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: which valid entries an op would clear, straight from the INVTLB rules
  function automatic logic [15:0] model_mask(input logic [4:0] op, input logic [9:0] asid,
                                             input logic [18:0] vppn);
    logic [15:0] m;
    logic vh, ah, g, hit;
    m = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      vh  = tlb_ps[i] ? (tlb_vppn[i][18:9] == vppn[18:9]) : (tlb_vppn[i] == vppn);
      ah  = (tlb_asid[i] == asid);
      g   = tlb_g[i];
      hit = 1'b0;
      if (op <= 5'd1)      hit = 1'b1;
      else if (op == 5'd2) hit = g;
      else if (op == 5'd3) hit = !g;
      else if (op == 5'd4) hit = !g && ah;
      else if (op == 5'd5) hit = !g && ah && vh;
      else if (op == 5'd6) hit = (g || ah) && vh;
      m[i] = tlb_e[i] && hit;
    end
    return m;
  endfunction

  task automatic set_entry(input int i, input logic e, input logic g, input logic [9:0] asid,
                           input logic [18:0] vppn, input logic ps);
    tlb_e[i] = e; tlb_g[i] = g; tlb_asid[i] = asid; tlb_vppn[i] = vppn; tlb_ps[i] = ps;
  endtask

  task automatic setup_tlb(input int kind);
    for (int i = 0; i < TLBNUM; i++) begin
      case (kind)
        0: set_entry(i, 1'b1, 1'b0, 10'(i), 19'(i), 1'b0);
        1: set_entry(i, (i == 3) || (i == 7), (i == 3), 10'(i), 19'(i), 1'b0);
        2: set_entry(i, 1'b1, 1'b0, 10'h2A, (i == 5) ? 19'h12345 : 19'(i), 1'b0);
        3: if (i == 9) set_entry(i, 1'b1, 1'b1, 10'h3FF, {10'h091, 9'h0AB}, 1'b1);
           else        set_entry(i, 1'b1, 1'b0, 10'h000, 19'(i), 1'b0);
        4: set_entry(i, ($urandom % 4) != 0, 1'($urandom % 2), 10'($urandom % 4),
                     19'((($urandom % 4) << 9) | ($urandom % 4)), ($urandom % 4) == 0);
        default: ;
      endcase
    end
  endtask

  // One op from accept to the first idle cycle afterwards; flush_at counts cycles after accept
  task automatic run_op(input string tag, input logic [4:0] op, input logic [9:0] asid,
                        input logic [31:0] va, input int flush_at, input logic [15:0] exp_mask);
    logic [15:0] got, cut;
    logic [4:0]  exp_v;
    logic        err, fl;
    int          last;
    err  = (op > 5'd6);
    last = err ? 1 : TLBNUM + 1;
    cut  = (flush_at >= 1 && flush_at <= TLBNUM) ? 16'((32'd1 << flush_at) - 1) : 16'hFFFF;
    got  = '0;
    @(posedge clk); #1;
    start_valid = 1'b1; start_op = op; start_asid = asid; start_va = va;
    @(negedge clk);
    chk({tag, "_accept"}, 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0; start_op = $urandom; start_asid = $urandom; start_va = $urandom;
    for (int k = 1; k <= last + 1; k++) begin
      fl = (k == flush_at);
      flush = fl;
      @(negedge clk);
      if ((flush_at > 0 && k == flush_at + 1) || k == last + 1) begin
        chk({tag, "_idle"}, 32'({start_ready, busy, done, op_err, inv_we}), 32'(5'b10000));
        @(posedge clk); #1;
        break;
      end
      if (err)             exp_v = {1'b0, 1'b1, !fl, !fl, 1'b0};
      else if (k <= TLBNUM) exp_v = {1'b0, 1'b1, 1'b0, 1'b0, exp_mask[k-1]};
      else                 exp_v = {1'b0, 1'b1, !fl, 1'b0, 1'b0};
      chk({tag, "_cyc"}, 32'({start_ready, busy, done, op_err, inv_we}), 32'(exp_v));
      if (!err && k <= TLBNUM) chk({tag, "_rindex"}, 32'(r_index), 32'(k - 1));
      if (inv_we) begin
        got[inv_index] = 1'b1;
        tlb_e[inv_index] = 1'b0;
      end
      @(posedge clk); #1;
      flush = 1'b0;
    end
    flush = 1'b0;
    chk({tag, "_invset"}, 32'(got), 32'(exp_mask & cut));
  endtask

  initial begin
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [31:0] va;
    int          fa, pick;

    vecs[0] = '{0, 5'd0, 10'h000, 32'h0000_0000, 0, 16'hFFFF};
    vecs[1] = '{1, 5'd2, 10'h000, 32'h0000_0000, 0, 16'h0008};
    vecs[2] = '{1, 5'd3, 10'h000, 32'h0000_0000, 0, 16'h0080};
    vecs[3] = '{2, 5'd5, 10'h02A, 32'h2468_A000, 0, 16'h0020};
    vecs[4] = '{2, 5'd5, 10'h02B, 32'h2468_A000, 0, 16'h0000};
    vecs[5] = '{3, 5'd6, 10'h001, {10'h091, 9'h155, 13'h0}, 0, 16'h0200};
    vecs[6] = '{0, 5'd7, 10'h000, 32'h0000_0000, 0, 16'h0000};
    vecs[7] = '{0, 5'd1, 10'h000, 32'h0000_0000, 4, 16'h000F};
    vecs[8] = '{-1, 5'd0, 10'h000, 32'h0000_0000, 0, 16'hFFF0};
    vecs[9] = '{0, 5'd4, 10'h003, 32'h0000_0000, 0, 16'h0008};

    reset = 1'b1; start_valid = 1'b0; start_op = '0; start_asid = '0; start_va = '0; flush = 1'b0;
    setup_tlb(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 32'({start_ready, busy, done, op_err, inv_we}), 32'(5'b10000));
    chk("reset_idx", 32'({r_index, inv_index}), 32'd0);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].setup >= 0) setup_tlb(vecs[v].setup);
      run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].asid, vecs[v].va,
             vecs[v].flush_at, vecs[v].mask);
    end

    // reset in the middle of a walk returns every output to its reset value
    setup_tlb(0);
    @(posedge clk); #1;
    start_valid = 1'b1; start_op = 5'd0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_ctrl", 32'({start_ready, busy, done, op_err, inv_we}), 32'(5'b10000));
    chk("midreset_idx", 32'({r_index, inv_index}), 32'd0);

    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 0) setup_tlb(4);
      op   = ($urandom % 5 == 0) ? 5'(7 + $urandom % 25) : 5'($urandom % 7);
      pick = int'($urandom % TLBNUM);
      asid = ($urandom % 2) ? tlb_asid[pick] : 10'($urandom % 4);
      vppn = ($urandom % 2) ? tlb_vppn[pick] : 19'((($urandom % 4) << 9) | ($urandom % 4));
      if ($urandom % 3 == 0) vppn[8:0] = 9'($urandom);
      va   = {vppn, 13'($urandom)};
      fa   = ($urandom % 4 == 0) ? 1 + int'($urandom % ((op > 5'd6) ? 1 : 17)) : 0;
      run_op($sformatf("rnd%0d", n), op, asid, va, fa, model_mask(op, asid, vppn));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
